// File: rtl/sm_alu_seq_if.sv
// Request/response bundle for the sign-magnitude sequential ALU.
// start is sampled only while the ALU is idle; busy is high from the cycle
// after a start is accepted until the done cycle inclusive; done is a
// single-cycle pulse and R/REM/flags are valid from that cycle until the
// next operation's done.
interface sm_alu_seq_if #(
   parameter int W = 3
);
   logic           start;
   logic [1:0]     OP;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic [2*W-2:0] R;
   logic [W-1:0]   REM;
   logic           busy;
   logic           done;
   logic           ZF;
   logic           SF;
   logic           DZF;
   logic [1:0]     state_dbg;

   modport master (
      output start, OP, A, B,
      input  R, REM, busy, done, ZF, SF, DZF, state_dbg
   );

   modport slave (
      input  start, OP, A, B,
      output R, REM, busy, done, ZF, SF, DZF, state_dbg
   );
endinterface

// File: rtl/sm_alu_seq.sv
// Sequential sign-magnitude ALU: single-cycle add/sub, shift-add multiply
// and restoring divide, one magnitude bit per CALC cycle.
module sm_alu_seq #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   sm_alu_seq_if.slave  bus
);
   localparam int M  = W - 1;          // magnitude width
   localparam int PW = 2 * W - 2;      // product magnitude width
   localparam int CW = $clog2(W);      // iteration counter width
   localparam logic [CW-1:0] LAST = CW'(W - 2);

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   // captured operands; signs are normalised so -0 behaves as +0
   logic [1:0]      op_r;
   logic            sa, sb;
   logic [M-1:0]    a_mag, b_mag;
   logic [CW-1:0]   cnt;

   // multiply working registers
   logic [PW-1:0]   acc, mcand;
   logic [M-1:0]    mplier;

   // divide working registers
   logic [M-1:0]    pr, dvd, quo;

   // registered results
   logic [2*W-2:0]  r_q;
   logic [W-1:0]    rem_q;
   logic            zf_q, sf_q, dzf_q;

   // combinational helpers
   logic            accept, div_zero, calc_last;
   logic [PW-1:0]   acc_nxt;
   logic [W-1:0]    trial;
   logic            ge;
   logic [M-1:0]    pr_nxt, quo_nxt;
   logic            sb_eff, add_sign;
   logic [W-1:0]    add_mag;
   logic [PW-1:0]   r_mag;
   logic            r_sign;
   logic [2*W-2:0]  r_nxt;
   logic [W-1:0]    rem_nxt;
   logic            zf_nxt, sf_nxt, dzf_nxt;

   assign accept    = (state == IDLE) && bus.start;
   assign div_zero  = (op_r == OP_DIV) && (b_mag == '0);
   // add/sub and divide-by-zero finish in one CALC cycle
   assign calc_last = !op_r[1] || div_zero || (cnt == LAST);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = CALC;
         CALC:    if (calc_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Arithmetic step and result formatting for the current CALC cycle
   always_comb begin
      acc_nxt  = mplier[0] ? (acc + mcand) : acc;

      trial    = {pr, dvd[M-1]};
      ge       = (trial >= {1'b0, b_mag});
      pr_nxt   = ge ? M'(trial - {1'b0, b_mag}) : trial[M-1:0];
      quo_nxt  = {quo[M-2:0], ge};

      sb_eff   = sb ^ (op_r == OP_SUB);
      add_mag  = '0;
      add_sign = 1'b0;
      if (sa == sb_eff) begin
         add_mag  = {1'b0, a_mag} + {1'b0, b_mag};
         add_sign = sa;
      end else if (a_mag >= b_mag) begin
         add_mag  = {1'b0, a_mag - b_mag};
         add_sign = sa;
      end else begin
         add_mag  = {1'b0, b_mag - a_mag};
         add_sign = sb_eff;
      end

      r_mag   = '0;
      r_sign  = 1'b0;
      rem_nxt = '0;
      dzf_nxt = 1'b0;
      case (op_r)
         OP_ADD, OP_SUB: begin
            r_mag  = PW'(add_mag);
            r_sign = add_sign;
         end
         OP_MUL: begin
            r_mag  = acc_nxt;
            r_sign = sa ^ sb;
         end
         default: begin
            if (div_zero) begin
               dzf_nxt = 1'b1;
            end else begin
               r_mag   = PW'(quo_nxt);
               r_sign  = sa ^ sb;
               rem_nxt = {sa & (pr_nxt != '0), pr_nxt};
            end
         end
      endcase

      // a zero magnitude is always reported as +0
      zf_nxt = (r_mag == '0);
      sf_nxt = r_sign & !zf_nxt;
      r_nxt  = {sf_nxt, r_mag};
   end

   // Operand capture on accept, one iteration per CALC cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_r   <= '0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         a_mag  <= '0;
         b_mag  <= '0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         pr     <= '0;
         dvd    <= '0;
         quo    <= '0;
      end else if (accept) begin
         op_r   <= bus.OP;
         sa     <= bus.A[W-1] & (|bus.A[M-1:0]);
         sb     <= bus.B[W-1] & (|bus.B[M-1:0]);
         a_mag  <= bus.A[M-1:0];
         b_mag  <= bus.B[M-1:0];
         cnt    <= '0;
         acc    <= '0;
         mcand  <= PW'(bus.A[M-1:0]);
         mplier <= bus.B[M-1:0];
         pr     <= '0;
         dvd    <= bus.A[M-1:0];
         quo    <= '0;
      end else if (state == CALC) begin
         cnt    <= cnt + CW'(1);
         acc    <= acc_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         pr     <= pr_nxt;
         dvd    <= dvd << 1;
         quo    <= quo_nxt;
      end
   end

   // Result registers load only on the CALC -> DONE transition
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q   <= '0;
         rem_q <= '0;
         zf_q  <= 1'b0;
         sf_q  <= 1'b0;
         dzf_q <= 1'b0;
      end else if ((state == CALC) && calc_last) begin
         r_q   <= r_nxt;
         rem_q <= rem_nxt;
         zf_q  <= zf_nxt;
         sf_q  <= sf_nxt;
         dzf_q <= dzf_nxt;
      end
   end

   assign bus.R         = r_q;
   assign bus.REM       = rem_q;
   assign bus.ZF        = zf_q;
   assign bus.SF        = sf_q;
   assign bus.DZF       = dzf_q;
   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.state_dbg = state;
endmodule
